sr_unload: RTL and testbench

SR_UNLOAD -- requirements
Module: sr_unload

---
 rtl/sr_unload.sv | 64 ++++++
 tb/tb_sr_unload.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_unload.sv
// sr_unload: captures a MOV word and streams it out as W-bit slices over a valid/ready handshake.
module sr_unload #(
  parameter int N = 10,
  parameter int W = 2,
  parameter int MSB_FIRST = 0,
  localparam int S = N / W,
  localparam int IW = (S > 1) ? $clog2(S) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  sr_q,
  input  logic          start,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          aborted
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam logic [IW-1:0] FIRST = (MSB_FIRST != 0) ? IW'(S - 1) : '0;
  localparam logic [IW-1:0] LAST  = (MSB_FIRST != 0) ? '0 : IW'(S - 1);
  state_t              state_q;
  logic [S-1:0][W-1:0] shadow_q;
  logic [IW-1:0]       idx_q;
  logic                aborted_q;
  // Unload FSM: capture on start, step the slice index on each transfer, abort returns straight to IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          shadow_q <= sr_q;
          idx_q    <= FIRST;
          state_q  <= SEND;
        end
        SEND: if (abort) begin
          state_q   <= IDLE;
          aborted_q <= 1'b1;
        end else if (out_ready) begin
          if (idx_q == LAST) state_q <= DONE;
          else idx_q <= (MSB_FIRST != 0) ? idx_q - 1'b1 : idx_q + 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_valid = state_q == SEND;
  assign out_data  = shadow_q[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = out_valid && idx_q == LAST;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign aborted   = aborted_q;
endmodule

// File: tb/tb_sr_unload.sv
// tb_sr_unload: scoreboard bench for sr_unload covering LSB/MSB order, stalls, abort, reset and S=1.
module tb_sr_unload;
  logic clk = 0, rst_n = 0, abort = 0, out_ready = 1;
  logic start0 = 0, start1 = 0, start2 = 0;
  logic [9:0] sr_q = '0;
  logic v0, l0, b0, dn0, a0, v1, l1, b1, dn1, a1, v2, l2, b2, dn2, a2;
  logic [1:0] d0, d1, d2;
  logic [2:0] i0, i1;
  logic [0:0] i2;
  int n_cmp = 0, n_bad = 0;
  logic [5:0] q0[$], q1[$], q2[$];
  int c, nd, na, dc;

  sr_unload #(.N(10), .W(2), .MSB_FIRST(0)) u0 (.clk(clk), .rst_n(rst_n), .sr_q(sr_q), .start(start0),
    .abort(abort), .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_idx(i0), .out_last(l0),
    .busy(b0), .done(dn0), .aborted(a0));
  sr_unload #(.N(10), .W(2), .MSB_FIRST(1)) u1 (.clk(clk), .rst_n(rst_n), .sr_q(sr_q), .start(start1),
    .abort(abort), .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_idx(i1), .out_last(l1),
    .busy(b1), .done(dn1), .aborted(a1));
  sr_unload #(.N(2), .W(2), .MSB_FIRST(0)) u2 (.clk(clk), .rst_n(rst_n), .sr_q(sr_q[1:0]), .start(start2),
    .abort(abort), .out_valid(v2), .out_ready(out_ready), .out_data(d2), .out_idx(i2), .out_last(l2),
    .busy(b2), .done(dn2), .aborted(a2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] ent(input logic l, input logic [2:0] i, input logic [1:0] d);
    return {l, i, d};
  endfunction

  // Monitor: every accepted beat is popped from its instance queue and compared
  always @(negedge clk) begin
    if (rst_n && !abort) begin
      if (v0 && out_ready) begin
        if (q0.size() == 0) chk("u0_unexpected_beat", 0, 1);
        else chk("u0_beat", {26'd0, l0, i0, d0}, {26'd0, q0.pop_front()});
      end
      if (v1 && out_ready) begin
        if (q1.size() == 0) chk("u1_unexpected_beat", 0, 1);
        else chk("u1_beat", {26'd0, l1, i1, d1}, {26'd0, q1.pop_front()});
      end
      if (v2 && out_ready) begin
        if (q2.size() == 0) chk("u2_unexpected_beat", 0, 1);
        else chk("u2_beat", {26'd0, l2, 2'b00, i2, d2}, {26'd0, q2.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_lsb;
    q0.push_back(ent(0, 0, 2'b01));
    q0.push_back(ent(0, 1, 2'b01));
    q0.push_back(ent(0, 2, 2'b11));
    q0.push_back(ent(0, 3, 2'b10));
    q0.push_back(ent(1, 4, 2'b10));
  endtask

  // Counts busy cycles from the next falling edge until the instance is idle again
  task automatic wait_idle(input int u, output int cc, output int nnd, output int nna, output int ddc);
    logic bz, dn, ab;
    bit hit;
    hit = 0; cc = 0; nnd = 0; nna = 0; ddc = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      bz = u == 0 ? b0 : u == 1 ? b1 : b2;
      dn = u == 0 ? dn0 : u == 1 ? dn1 : dn2;
      ab = u == 0 ? a0 : u == 1 ? a1 : a2;
      nnd += int'(dn);
      nna += int'(ab);
      if (dn) ddc = cc + 1;
      if (!bz) hit = 1;
      else begin
        cc++;
        tick();
      end
    end
    if (!hit) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    @(negedge clk);
    chk("rst_u0_outs", {v0, d0, i0, l0, b0, dn0, a0}, 0);
    chk("rst_u1_outs", {v1, d1, i1, l1, b1, dn1, a1}, 0);
    chk("rst_u2_outs", {v2, d2, i2, l2, b2, dn2, a2}, 0);
    rst_n = 1;
    // LSB-first basic unload
    tick();
    sr_q = 10'h2B5;
    push_lsb();
    start0 = 1;
    tick();
    start0 = 0;
    wait_idle(0, c, nd, na, dc);
    chk("lsb_start_to_idle", c + 1, 7);
    chk("lsb_done_count", nd, 1);
    chk("lsb_done_cycle", dc, 6);
    chk("lsb_aborted_count", na, 0);
    chk("lsb_q_drained", q0.size(), 0);
    // MSB-first unload
    tick();
    q1.push_back(ent(0, 4, 2'b10));
    q1.push_back(ent(0, 3, 2'b10));
    q1.push_back(ent(0, 2, 2'b11));
    q1.push_back(ent(0, 1, 2'b01));
    q1.push_back(ent(1, 0, 2'b01));
    start1 = 1;
    tick();
    start1 = 0;
    wait_idle(1, c, nd, na, dc);
    chk("msb_busy_cycles", c, 6);
    chk("msb_done_count", nd, 1);
    chk("msb_q_drained", q1.size(), 0);
    // Backpressure at idx 2 with sr_q changed after capture
    tick();
    push_lsb();
    start0 = 1;
    tick();
    start0 = 0;
    sr_q = 10'h000;
    tick(); tick();
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_beat", {v0, l0, i0, d0}, {1'b1, 1'b0, 3'd2, 2'b11});
      tick();
    end
    out_ready = 1;
    wait_idle(0, c, nd, na, dc);
    chk("stall_done_count", nd, 1);
    chk("stall_q_drained", q0.size(), 0);
    // Abort together with the idx 1 handshake
    tick();
    sr_q = 10'h2B5;
    q0.push_back(ent(0, 0, 2'b01));
    start0 = 1;
    tick();
    start0 = 0;
    tick();
    abort = 1;
    @(negedge clk);
    chk("abort_presented", {v0, i0}, {1'b1, 3'd1});
    tick();
    abort = 0;
    @(negedge clk);
    chk("abort_pulse", {a0, b0, v0, dn0}, 4'b1000);
    tick();
    @(negedge clk);
    chk("abort_one_cycle", {a0, dn0}, 2'b00);
    chk("abort_q_drained", q0.size(), 0);
    tick();
    push_lsb();
    start0 = 1;
    tick();
    start0 = 0;
    wait_idle(0, c, nd, na, dc);
    chk("post_abort_done", nd, 1);
    chk("post_abort_q_drained", q0.size(), 0);
    // Reset at idx 3 with start held during reset
    tick();
    q0.push_back(ent(0, 0, 2'b01));
    q0.push_back(ent(0, 1, 2'b01));
    q0.push_back(ent(0, 2, 2'b11));
    start0 = 1;
    tick();
    start0 = 0;
    tick(); tick(); tick();
    rst_n = 0;
    start0 = 1;
    @(negedge clk);
    chk("pre_reset_idx", {v0, i0}, {1'b1, 3'd3});
    tick();
    @(negedge clk);
    chk("midrst_outs", {v0, d0, i0, l0, b0, dn0, a0}, 0);
    tick();
    @(negedge clk);
    chk("midrst_outs_hold", {v0, d0, i0, l0, b0, dn0, a0}, 0);
    rst_n = 1;
    start0 = 0;
    tick();
    @(negedge clk);
    chk("post_reset_idle", {b0, dn0, a0, v0}, 0);
    chk("reset_q_drained", q0.size(), 0);
    // Start held through an unload restarts only from IDLE
    tick();
    push_lsb();
    push_lsb();
    start0 = 1;
    tick();
    wait_idle(0, c, nd, na, dc);
    chk("held_first_busy", c, 6);
    chk("held_first_done", nd, 1);
    tick();
    @(negedge clk);
    chk("held_restart", {b0, v0, i0}, {1'b1, 1'b1, 3'd0});
    start0 = 0;
    tick();
    wait_idle(0, c, nd, na, dc);
    chk("held_second_busy", c, 5);
    chk("held_second_done", nd, 1);
    chk("held_q_drained", q0.size(), 0);
    // Single-slice configuration
    tick();
    q2.push_back(ent(1, 0, 2'b01));
    start2 = 1;
    tick();
    start2 = 0;
    wait_idle(2, c, nd, na, dc);
    chk("s1_busy_cycles", c, 2);
    chk("s1_done_count", nd, 1);
    chk("s1_q_drained", q2.size(), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
